// File: rtl/bakraid_prog_buf_if.sv
// Loader-side byte strobes and SDRAM programming port of the program buffer.
// The master drives strobes and the controller handshake; the slave is the buffer.
interface bakraid_prog_buf_if;
    logic        IN_WE;
    logic [21:0] IN_ADDR;
    logic [1:0]  IN_BA;
    logic [15:0] IN_DATA;
    logic [1:0]  IN_MASK;
    logic        IN_READY;
    logic        DOWNLOADING;
    logic [21:0] PROG_ADDR;
    logic [1:0]  PROG_BA;
    logic [15:0] PROG_DATA;
    logic [1:0]  PROG_MASK;
    logic        PROG_WE;
    logic        PROG_RDY;
    logic        BUSY;
    logic        OVERFLOW;

    modport master (
        output IN_WE, IN_ADDR, IN_BA, IN_DATA, IN_MASK, DOWNLOADING, PROG_RDY,
        input  IN_READY, PROG_ADDR, PROG_BA, PROG_DATA, PROG_MASK, PROG_WE, BUSY, OVERFLOW
    );

    modport slave (
        input  IN_WE, IN_ADDR, IN_BA, IN_DATA, IN_MASK, DOWNLOADING, PROG_RDY,
        output IN_READY, PROG_ADDR, PROG_BA, PROG_DATA, PROG_MASK, PROG_WE, BUSY, OVERFLOW
    );
endinterface

// File: rtl/bakraid_prog_buf.sv
// Merges byte writes from the ROM loader into 16-bit SDRAM words and queues them
// through a small FIFO towards the SDRAM controller's programming port.
module bakraid_prog_buf #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    bakraid_prog_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    typedef struct packed {
        logic [21:0] addr;
        logic [1:0]  ba;
        logic [15:0] data;
        logic [1:0]  mask;
    } word_t;

    word_t          fifo_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q;

    logic           pend_vld_q, pend_vld_d;
    word_t          pend_q, pend_d;
    logic [7:0]     idle_q, idle_d;
    logic           dl_q, flush_q, flush_d;
    logic           ovf_q, rdy_q;
    logic [1:0]     state_q;
    word_t          prog_q;

    logic           full, pop, push, push_ok, accept, merge, timeout, flush_req;
    word_t          in_w, merged_w, push_w;

    assign full      = (cnt_q == CW'(DEPTH));
    assign pop       = (state_q == S_WRITE) && bus.PROG_RDY;
    assign push_ok   = !full || pop;
    assign accept    = bus.IN_WE && bus.IN_READY;
    assign timeout   = pend_vld_q && (idle_q == 8'(TIMEOUT - 1));
    assign flush_req = (dl_q && !bus.DOWNLOADING) || flush_q;

    assign in_w  = '{addr: bus.IN_ADDR, ba: bus.IN_BA, data: bus.IN_DATA, mask: bus.IN_MASK};
    assign merge = pend_vld_q && (bus.IN_ADDR == pend_q.addr) && (bus.IN_BA == pend_q.ba) &&
                   ((pend_q.mask | bus.IN_MASK) == 2'b11);

    // Upper byte comes from whichever byte wrote the upper half (mask 01), lower likewise.
    always_comb begin
        merged_w      = in_w;
        merged_w.mask = 2'b00;
        merged_w.data[15:8] = (pend_q.mask == 2'b01) ? pend_q.data[15:8] : bus.IN_DATA[15:8];
        merged_w.data[7:0]  = (pend_q.mask == 2'b10) ? pend_q.data[7:0]  : bus.IN_DATA[7:0];
    end

    // A new strobe wins over timeout/flush in the same cycle; a pending flush request survives it.
    always_comb begin
        push       = 1'b0;
        push_w     = pend_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        flush_d    = flush_req;
        idle_d     = idle_q;
        if (accept) begin
            idle_d = '0;
            if (!pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_d     = in_w;
            end else if (merge) begin
                push       = 1'b1;
                push_w     = merged_w;
                pend_vld_d = 1'b0;
            end else begin
                push       = 1'b1;
                pend_d     = in_w;
            end
        end else begin
            if (pend_vld_q && idle_q < 8'(TIMEOUT - 1))
                idle_d = idle_q + 8'd1;
            if ((timeout || flush_req) && push_ok) begin
                push       = pend_vld_q;
                pend_vld_d = 1'b0;
                flush_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            idle_q     <= '0;
            dl_q       <= 1'b0;
            flush_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            idle_q     <= idle_d;
            dl_q       <= bus.DOWNLOADING;
            flush_q    <= flush_d;
            rdy_q      <= 1'b1;
            if (bus.IN_WE && !bus.IN_READY)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            fifo_q[wr_ptr_q] <= push_w;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // The head stays in the FIFO until the controller acknowledges it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            prog_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cnt_q != '0) begin
                    prog_q  <= fifo_q[rd_ptr_q];
                    state_q <= S_WRITE;
                end
                S_WRITE: if (bus.PROG_RDY) state_q <= S_GAP;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.IN_READY  = rdy_q && !full;
    assign bus.PROG_ADDR = prog_q.addr;
    assign bus.PROG_BA   = prog_q.ba;
    assign bus.PROG_DATA = prog_q.data;
    assign bus.PROG_MASK = prog_q.mask;
    assign bus.PROG_WE   = (state_q == S_WRITE);
    assign bus.BUSY      = pend_vld_q || (cnt_q != '0) || bus.PROG_WE;
    assign bus.OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_bakraid_prog_buf.sv
// Self-checking bench for bakraid_prog_buf: directed scenarios plus a randomized
// run scored against a transaction-level merge/timeout model.
module tb_bakraid_prog_buf;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [21:0] addr;
        logic [1:0]  ba;
        logic [15:0] data;
        logic [1:0]  mask;
    } wr_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    bakraid_prog_buf_if bus ();

    bakraid_prog_buf #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
    );

    task automatic reset_dut();
        RESET_N = 1'b0;
        bus.IN_WE = 1'b0; bus.IN_ADDR = '0; bus.IN_BA = '0; bus.IN_DATA = '0; bus.IN_MASK = 2'b11;
        bus.PROG_RDY = 1'b0; bus.DOWNLOADING = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic strobe(input logic [21:0] a, input logic [1:0] b, input logic [1:0] m, input logic [7:0] byt);
        bus.IN_WE = 1'b1; bus.IN_ADDR = a; bus.IN_BA = b; bus.IN_MASK = m; bus.IN_DATA = {byt, byt};
        @(posedge CLK); #1 bus.IN_WE = 1'b0;
    endtask

    // Waits for PROG_WE, captures the word, then acknowledges it after dly cycles.
    task automatic take_write(input int dly, output wr_t w, output bit ok);
        ok = 1'b0;
        w  = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (bus.PROG_WE) begin ok = 1'b1; break; end
        end
        if (ok) begin
            w = '{addr: bus.PROG_ADDR, ba: bus.PROG_BA, data: bus.PROG_DATA, mask: bus.PROG_MASK};
            repeat (dly) @(negedge CLK);
            bus.PROG_RDY = 1'b1;
            @(posedge CLK); #1 bus.PROG_RDY = 1'b0;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        bus.IN_WE = 1'b0; bus.PROG_RDY = 1'b0; bus.DOWNLOADING = 1'b1;
        bus.IN_ADDR = '0; bus.IN_BA = '0; bus.IN_DATA = '0; bus.IN_MASK = 2'b11;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++; if (bus.PROG_ADDR !== 22'h0) begin errors++; $display("FAIL reset_prog_addr got %h want 0", bus.PROG_ADDR); end
        checks++; if (bus.PROG_BA !== 2'h0) begin errors++; $display("FAIL reset_prog_ba got %h want 0", bus.PROG_BA); end
        checks++; if (bus.PROG_DATA !== 16'h0) begin errors++; $display("FAIL reset_prog_data got %h want 0", bus.PROG_DATA); end
        checks++; if (bus.PROG_MASK !== 2'h0) begin errors++; $display("FAIL reset_prog_mask got %h want 0", bus.PROG_MASK); end
        checks++; if (bus.PROG_WE !== 1'b0) begin errors++; $display("FAIL reset_prog_we got %b want 0", bus.PROG_WE); end
        checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.IN_READY); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
        checks++; if (bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.OVERFLOW); end
        RESET_N = 1'b1;
        #1;
        checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL release_ready_early got %b want 0", bus.IN_READY); end
        @(negedge CLK);
        checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL release_ready_first_edge got %b want 1", bus.IN_READY); end
    endtask

    task automatic test_merge();
        wr_t w; bit ok; int extra = 0;
        reset_dut();
        strobe(22'h000010, 2'd0, 2'b01, 8'hAA);
        strobe(22'h000010, 2'd0, 2'b10, 8'h55);
        take_write(1, w, ok);
        checks++; if (!ok) begin errors++; $display("FAIL merge_write_seen got none want one"); end
        checks++; if (w !== wr_t'{22'h000010, 2'd0, 16'hAA55, 2'b00})
            begin errors++; $display("FAIL merge_word got %h/%h/%h/%h want 000010/0/aa55/0", w.addr, w.ba, w.data, w.mask); end
        repeat (TIMEOUT + 6) begin @(negedge CLK); if (bus.PROG_WE) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL merge_extra_write got %0d cycles want 0", extra); end
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL merge_busy_after got %b want 0", bus.BUSY); end
    endtask

    task automatic test_timeout();
        int first = -1;
        reset_dut();
        strobe(22'h000020, 2'd0, 2'b10, 8'h3C);
        for (int j = 0; j <= TIMEOUT + 5; j++) begin
            @(negedge CLK);
            if (bus.PROG_WE && first < 0) first = j;
        end
        checks++; if (first != TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", first, TIMEOUT + 1); end
        checks++; if (bus.PROG_DATA !== 16'h3C3C || bus.PROG_MASK !== 2'b10)
            begin errors++; $display("FAIL timeout_word got %h/%h want 3c3c/2", bus.PROG_DATA, bus.PROG_MASK); end
        bus.PROG_RDY = 1'b1; @(posedge CLK); #1 bus.PROG_RDY = 1'b0;
    endtask

    task automatic test_no_merge_ba();
        wr_t w1, w2; bit ok1, ok2;
        reset_dut();
        strobe(22'h000010, 2'd0, 2'b01, 8'hAA);
        strobe(22'h000010, 2'd1, 2'b10, 8'h55);
        take_write(0, w1, ok1);
        take_write(2, w2, ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL ba_two_writes got %0d%0d want 11", ok1, ok2); end
        checks++; if (w1 !== wr_t'{22'h000010, 2'd0, 16'hAAAA, 2'b01})
            begin errors++; $display("FAIL ba_first got %h/%h/%h/%h want 000010/0/aaaa/1", w1.addr, w1.ba, w1.data, w1.mask); end
        checks++; if (w2 !== wr_t'{22'h000010, 2'd1, 16'h5555, 2'b10})
            begin errors++; $display("FAIL ba_second got %h/%h/%h/%h want 000010/1/5555/2", w2.addr, w2.ba, w2.data, w2.mask); end
    endtask

    task automatic test_flush();
        int first = -1;
        reset_dut();
        strobe(22'h000030, 2'd2, 2'b01, 8'h77);
        bus.DOWNLOADING = 1'b0;
        for (int j = 0; j < TIMEOUT; j++) begin
            @(negedge CLK);
            if (bus.PROG_WE) begin first = j; break; end
        end
        checks++; if (first < 0 || first > 3) begin errors++; $display("FAIL flush_latency got %0d want <=3", first); end
        checks++; if (bus.PROG_ADDR !== 22'h000030 || bus.PROG_BA !== 2'd2 || bus.PROG_DATA !== 16'h7777 || bus.PROG_MASK !== 2'b01)
            begin errors++; $display("FAIL flush_word got %h/%h/%h/%h want 000030/2/7777/1", bus.PROG_ADDR, bus.PROG_BA, bus.PROG_DATA, bus.PROG_MASK); end
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL flush_busy_during got %b want 1", bus.BUSY); end
        bus.PROG_RDY = 1'b1; @(posedge CLK); #1 bus.PROG_RDY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (bus.BUSY !== 1'b0 || bus.PROG_WE !== 1'b0)
            begin errors++; $display("FAIL flush_busy_after got %b/%b want 0/0", bus.BUSY, bus.PROG_WE); end
        bus.DOWNLOADING = 1'b1;
    endtask

    task automatic test_overflow();
        wr_t w; bit ok; int extra = 0;
        reset_dut();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            // DEPTH pushed entries plus one pending byte fit; everything after is dropped.
            checks++; if (bus.IN_READY !== (i <= DEPTH))
                begin errors++; $display("FAIL ovf_ready_%0d got %b want %b", i, bus.IN_READY, (i <= DEPTH)); end
            strobe(22'h000100 + 22'(i), 2'd0, 2'b01, 8'(i + 1));
        end
        checks++; if (bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.OVERFLOW); end
        repeat (TIMEOUT + 4) @(posedge CLK);
        #1;
        for (int k = 0; k <= DEPTH; k++) begin
            take_write($urandom_range(0, 2), w, ok);
            checks++;
            if (!ok || w !== wr_t'{22'h000100 + 22'(k), 2'd0, {8'(k + 1), 8'(k + 1)}, 2'b01})
                begin errors++; $display("FAIL ovf_drain_%0d got %0d:%h/%h/%h want %h/%h/1", k, ok, w.addr, w.data, w.mask, 22'h000100 + 22'(k), {8'(k + 1), 8'(k + 1)}); end
        end
        repeat (TIMEOUT + 6) begin @(negedge CLK); if (bus.PROG_WE) extra++; end
        checks++; if (extra != 0 || bus.BUSY !== 1'b0)
            begin errors++; $display("FAIL ovf_drain_extra got %0d/%b want 0/0", extra, bus.BUSY); end
        checks++; if (bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.OVERFLOW); end
    endtask

    // Runs straight after the overflow test so the sticky flag is still set going in.
    task automatic test_reset_mid_write();
        bit seen = 1'b0; int extra = 0;
        strobe(22'h000050, 2'd0, 2'b01, 8'h11);
        strobe(22'h000051, 2'd0, 2'b01, 8'h22);
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge CLK); seen = bus.PROG_WE; end
        checks++; if (!seen) begin errors++; $display("FAIL rmw_enter_write got none want PROG_WE"); end
        #2 RESET_N = 1'b0;
        #1;
        checks++; if (bus.PROG_WE !== 1'b0) begin errors++; $display("FAIL rmw_we_async got %b want 0", bus.PROG_WE); end
        checks++; if (bus.OVERFLOW !== 1'b0 || bus.BUSY !== 1'b0)
            begin errors++; $display("FAIL rmw_state_cleared got %b/%b want 0/0", bus.OVERFLOW, bus.BUSY); end
        @(posedge CLK); #1 RESET_N = 1'b1;
        repeat (TIMEOUT + 8) begin @(negedge CLK); if (bus.PROG_WE) extra++; end
        checks++; if (extra != 0 || bus.BUSY !== 1'b0 || bus.IN_READY !== 1'b1)
            begin errors++; $display("FAIL rmw_after got %0d/%b/%b want 0/0/1", extra, bus.BUSY, bus.IN_READY); end
    endtask

    task automatic test_random();
        wr_t exp_q[$];
        wr_t pend, got, want;
        bit pv = 1'b0, drv_done = 1'b0;
        int pushes = 0, pops = 0, writes = 0, guard = 0;
        int unsigned last_edge = 0, edge_n;
        reset_dut();
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    logic [21:0] a; logic [1:0] b, m; logic [7:0] byt; int room;
                    if ($urandom_range(0, 4) == 0) begin
                        repeat (TIMEOUT) @(posedge CLK);
                        #1;
                        if (pv) begin exp_q.push_back(pend); pushes++; pv = 1'b0; end
                        repeat (4) @(posedge CLK);
                        #1;
                    end else begin
                        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                    end
                    room = 0;
                    while (pushes - pops > DEPTH - 2 && room < 500) begin @(posedge CLK); #1; room++; end
                    byt = 8'($urandom);
                    if (pv && $urandom_range(0, 1) == 1) begin
                        a = pend.addr;
                        b = ($urandom_range(0, 3) == 0) ? pend.ba ^ 2'd1 : pend.ba;
                        m = ($urandom_range(0, 3) == 0) ? pend.mask : ~pend.mask;
                    end else begin
                        a = 22'h000040 + 22'($urandom_range(0, 3));
                        b = 2'($urandom_range(0, 3));
                        m = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                    end
                    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL rand_ready_%0d got %b want 1", n, bus.IN_READY); end
                    strobe(a, b, m, byt);
                    edge_n = cyc;
                    if (pv && edge_n - last_edge > TIMEOUT) begin exp_q.push_back(pend); pushes++; pv = 1'b0; end
                    if (!pv) begin
                        pend = '{addr: a, ba: b, data: {byt, byt}, mask: m}; pv = 1'b1;
                    end else if (a == pend.addr && b == pend.ba && m != pend.mask) begin
                        want.addr = a; want.ba = b; want.mask = 2'b00;
                        want.data = (m == 2'b10) ? {pend.data[7:0], byt} : {byt, pend.data[7:0]};
                        exp_q.push_back(want); pushes++; pv = 1'b0;
                    end else begin
                        exp_q.push_back(pend); pushes++;
                        pend = '{addr: a, ba: b, data: {byt, byt}, mask: m};
                    end
                    last_edge = edge_n;
                end
                repeat (TIMEOUT) @(posedge CLK);
                #1;
                if (pv) begin exp_q.push_back(pend); pushes++; pv = 1'b0; end
                drv_done = 1'b1;
            end
            begin
                while (!(drv_done && exp_q.size() == 0) && guard < 20000) begin
                    @(negedge CLK);
                    guard++;
                    if (bus.PROG_WE) begin
                        got = '{addr: bus.PROG_ADDR, ba: bus.PROG_BA, data: bus.PROG_DATA, mask: bus.PROG_MASK};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_unexpected got %h/%h/%h/%h want none", got.addr, got.ba, got.data, got.mask);
                        end else begin
                            want = exp_q.pop_front();
                            if (got !== want) begin
                                errors++;
                                $display("FAIL rand_write_%0d got %h/%h/%h/%h want %h/%h/%h/%h", writes,
                                         got.addr, got.ba, got.data, got.mask, want.addr, want.ba, want.data, want.mask);
                            end
                        end
                        repeat ($urandom_range(0, 2)) @(negedge CLK);
                        bus.PROG_RDY = 1'b1;
                        @(posedge CLK); #1 bus.PROG_RDY = 1'b0;
                        pops++; writes++;
                    end
                end
            end
        join
        checks++; if (guard >= 20000) begin errors++; $display("FAIL rand_timeout got %0d left want 0", exp_q.size()); end
        repeat (3) @(negedge CLK);
        checks++; if (bus.BUSY !== 1'b0 || pushes != writes)
            begin errors++; $display("FAIL rand_drained got busy=%b writes=%0d want busy=0 writes=%0d", bus.BUSY, writes, pushes); end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_timeout();
        test_no_merge_ba();
        test_flush();
        test_overflow();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end
endmodule
